// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard control for a two-stage result pipeline.
// Tracks the two instructions ahead of decode and drives the One/Two bus selects.
module fwd_hazard_ctrl #(
  parameter int REG_BITS = 4,
  parameter bit ZERO_REG = 1'b1,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dec_valid,
  input  logic [REG_BITS-1:0] dec_src_a,
  input  logic [REG_BITS-1:0] dec_src_b,
  input  logic                dec_use_a,
  input  logic                dec_use_b,
  input  logic [REG_BITS-1:0] dec_dst,
  input  logic                dec_wr,
  input  logic                dec_load,
  input  logic                freeze,
  input  logic                flush,
  output logic                one_a,
  output logic                one_b,
  output logic                two_a,
  output logic                two_b,
  output logic                stall,
  output logic [CNT_BITS-1:0] stall_cnt
);

  logic                r_v1, r_wr1, r_ld1;
  logic [REG_BITS-1:0] r_dst1;
  logic                r_v2, r_wr2;
  logic [REG_BITS-1:0] r_dst2;
  logic [CNT_BITS-1:0] r_stall_cnt;

  logic w_zero_a, w_zero_b;
  logic w_hit1_a, w_hit1_b, w_hit2_a, w_hit2_b;
  logic w_stall, w_cnt_max;

  // Register 0 reads never match a producer when it is hardwired zero.
  assign w_zero_a = ZERO_REG && (dec_src_a == '0);
  assign w_zero_b = ZERO_REG && (dec_src_b == '0);

  assign w_hit1_a = dec_valid & dec_use_a & r_v1 & r_wr1 & (r_dst1 == dec_src_a) & ~w_zero_a;
  assign w_hit1_b = dec_valid & dec_use_b & r_v1 & r_wr1 & (r_dst1 == dec_src_b) & ~w_zero_b;
  assign w_hit2_a = dec_valid & dec_use_a & r_v2 & r_wr2 & (r_dst2 == dec_src_a) & ~w_zero_a;
  assign w_hit2_b = dec_valid & dec_use_b & r_v2 & r_wr2 & (r_dst2 == dec_src_b) & ~w_zero_b;

  assign w_stall   = (w_hit1_a | w_hit1_b) & r_ld1 & ~flush;
  assign w_cnt_max = &r_stall_cnt;

  // A load in S1 has no One result; the stalled operand waits for Two next cycle.
  assign one_a     = w_hit1_a & ~r_ld1 & ~rst;
  assign one_b     = w_hit1_b & ~r_ld1 & ~rst;
  assign two_a     = w_hit2_a & ~w_hit1_a & ~rst;
  assign two_b     = w_hit2_b & ~w_hit1_b & ~rst;
  assign stall     = w_stall & ~rst;
  assign stall_cnt = rst ? '0 : r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1        <= 1'b0;
      r_wr1       <= 1'b0;
      r_ld1       <= 1'b0;
      r_dst1      <= '0;
      r_v2        <= 1'b0;
      r_wr2       <= 1'b0;
      r_dst2      <= '0;
      r_stall_cnt <= '0;
    end else if (!freeze) begin
      r_v2   <= r_v1;
      r_wr2  <= r_wr1;
      r_dst2 <= r_dst1;
      r_v1   <= dec_valid & ~w_stall & ~flush;
      r_wr1  <= dec_wr;
      r_ld1  <= dec_load;
      r_dst1 <= dec_dst;
      if (w_stall && !w_cnt_max) begin
        r_stall_cnt <= r_stall_cnt + CNT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl (CNT_BITS=4 build so saturation is reachable).
// A reference model pushes expected outputs per cycle; they are popped and compared mid-cycle.
module tb_fwd_hazard_ctrl;

  localparam int RB = 4;
  localparam int CB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dec_valid = 1'b0, dec_use_a = 1'b0, dec_use_b = 1'b0;
  logic dec_wr = 1'b0, dec_load = 1'b0, freeze = 1'b0, flush = 1'b0;
  logic [RB-1:0] dec_src_a = '0, dec_src_b = '0, dec_dst = '0;
  logic one_a, one_b, two_a, two_b, stall;
  logic [CB-1:0] stall_cnt;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_BITS(RB), .ZERO_REG(1'b1), .CNT_BITS(CB)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_src_a(dec_src_a), .dec_src_b(dec_src_b),
    .dec_use_a(dec_use_a), .dec_use_b(dec_use_b), .dec_dst(dec_dst),
    .dec_wr(dec_wr), .dec_load(dec_load), .freeze(freeze), .flush(flush),
    .one_a(one_a), .one_b(one_b), .two_a(two_a), .two_b(two_b),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [3:0]    sel;   // {one_a, one_b, two_a, two_b}
    logic          stl;
    logic [CB-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference model state
  logic          m_v1 = 0, m_wr1 = 0, m_ld1 = 0, m_v2 = 0, m_wr2 = 0;
  logic [RB-1:0] m_dst1 = '0, m_dst2 = '0;
  logic [CB-1:0] m_cnt = '0;

  // Last sampled DUT outputs, for directed spot checks
  logic [3:0]    l_sel;
  logic          l_stall;
  logic [CB-1:0] l_cnt;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic ins(string tag, bit v, int sa, int sb, bit ua, bit ub, int d,
                     bit w, bit l, bit frz = 0, bit fl = 0, bit r = 0);
    logic h1a, h1b, h2a, h2b, e_stl;
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = r; dec_valid = v; dec_use_a = ua; dec_use_b = ub;
    dec_src_a = sa[RB-1:0]; dec_src_b = sb[RB-1:0]; dec_dst = d[RB-1:0];
    dec_wr = w; dec_load = l; freeze = frz; flush = fl;
    h1a = v && ua && m_v1 && m_wr1 && (m_dst1 == sa[RB-1:0]) && (sa[RB-1:0] != 0);
    h1b = v && ub && m_v1 && m_wr1 && (m_dst1 == sb[RB-1:0]) && (sb[RB-1:0] != 0);
    h2a = v && ua && m_v2 && m_wr2 && (m_dst2 == sa[RB-1:0]) && (sa[RB-1:0] != 0);
    h2b = v && ub && m_v2 && m_wr2 && (m_dst2 == sb[RB-1:0]) && (sb[RB-1:0] != 0);
    e_stl = (h1a || h1b) && m_ld1 && !fl;
    if (r) e = '0;
    else begin
      e.sel = {h1a && !m_ld1, h1b && !m_ld1, h2a && !h1a, h2b && !h1b};
      e.stl = e_stl;
      e.cnt = m_cnt;
    end
    exp_q.push_back(e);
    #2;
    got = {one_a, one_b, two_a, two_b, stall, stall_cnt};
    l_sel = got.sel; l_stall = got.stl; l_cnt = got.cnt;
    if (exp_q.size() == 0) chk({tag, "_queue"}, 0, 1);
    else begin
      e = exp_q.pop_front();
      chk({tag, "_sel"}, 32'(got.sel), 32'(e.sel));
      chk({tag, "_stall"}, 32'(got.stl), 32'(e.stl));
      chk({tag, "_cnt"}, 32'(got.cnt), 32'(e.cnt));
    end
    $display("[%0d] %s sel=%b stall=%b cnt=%0d", cyc, tag, got.sel, got.stl, got.cnt);
    @(posedge clk);
    cyc++;
    if (r) begin
      m_v1 = 0; m_wr1 = 0; m_ld1 = 0; m_dst1 = '0;
      m_v2 = 0; m_wr2 = 0; m_dst2 = '0; m_cnt = '0;
    end else if (!frz) begin
      m_v2 = m_v1; m_wr2 = m_wr1; m_dst2 = m_dst1;
      m_v1 = v && !e_stl && !fl; m_wr1 = w; m_ld1 = l; m_dst1 = d[RB-1:0];
      if (e_stl && m_cnt != {CB{1'b1}}) m_cnt = m_cnt + 1'b1;
    end
  endtask

  initial begin
    ins("reset", 1, 3, 4, 1, 1, 3, 1, 0, 0, 0, 1);
    ins("reset", 1, 3, 4, 1, 1, 3, 1, 1, 0, 0, 1);
    chk("reset_sel", 32'(l_sel), 0);
    chk("reset_cnt", 32'(l_cnt), 0);

    ins("rd_r3r4", 1, 3, 4, 1, 1, 0, 0, 0);
    chk("idle_sel", 32'(l_sel), 0);
    chk("idle_stall", 32'(l_stall), 0);

    ins("alu_r5", 1, 0, 0, 0, 0, 5, 1, 0);
    ins("rd_a_r5", 1, 5, 1, 1, 0, 0, 0, 0);
    chk("fwd_one_a", 32'(l_sel), 32'b1000);
    ins("alu_r6", 1, 0, 0, 0, 0, 6, 1, 0);
    ins("bubble", 0, 0, 0, 0, 0, 0, 0, 0);
    ins("rd_b_r6", 1, 1, 6, 0, 1, 0, 0, 0);
    chk("fwd_two_b", 32'(l_sel), 32'b0001);

    ins("ld_r2", 1, 0, 0, 0, 0, 2, 1, 1);
    ins("use_r2", 1, 2, 0, 1, 0, 0, 0, 0);
    chk("lu_stall", 32'(l_stall), 1);
    chk("lu_sel_blocked", 32'(l_sel), 0);
    ins("use_r2_rty", 1, 2, 0, 1, 0, 0, 0, 0);
    chk("lu_two_a", 32'(l_sel), 32'b0010);
    chk("lu_stall_off", 32'(l_stall), 0);
    chk("lu_cnt1", 32'(l_cnt), 1);

    ins("alu_r7", 1, 0, 0, 0, 0, 7, 1, 0);
    ins("alu_r7", 1, 0, 0, 0, 0, 7, 1, 0);
    ins("rd_ab_r7", 1, 7, 7, 1, 1, 0, 0, 0);
    chk("young_wins", 32'(l_sel), 32'b1100);
    ins("alu_r0", 1, 0, 0, 0, 0, 0, 1, 0);
    ins("alu_r0", 1, 0, 0, 0, 0, 0, 1, 0);
    ins("rd_ab_r0", 1, 0, 0, 1, 1, 0, 0, 0);
    chk("zero_reg", 32'(l_sel), 0);

    ins("ld_r9", 1, 0, 0, 0, 0, 9, 1, 1);
    ins("use_r9_flush", 1, 9, 0, 1, 0, 0, 0, 0, 0, 1);
    chk("flush_no_stall", 32'(l_stall), 0);
    ins("use_r9", 1, 9, 0, 1, 0, 0, 0, 0);
    chk("flush_two_a", 32'(l_sel), 32'b0010);

    ins("ld_r10", 1, 0, 0, 0, 0, 10, 1, 1);
    for (int i = 0; i < 3; i++) begin
      ins("use_r10_frz", 1, 10, 0, 1, 0, 0, 0, 0, 1);
      chk("frz_stall", 32'(l_stall), 1);
      chk("frz_cnt", 32'(l_cnt), 1);
    end
    ins("use_r10", 1, 10, 0, 1, 0, 0, 0, 0);
    ins("use_r10_rty", 1, 10, 0, 1, 0, 0, 0, 0);
    chk("frz_two_a", 32'(l_sel), 32'b0010);
    chk("frz_cnt2", 32'(l_cnt), 2);

    for (int i = 0; i < (1 << CB) + 5; i++) begin
      ins("sat_ld", 1, 0, 0, 0, 0, 12, 1, 1);
      ins("sat_use", 1, 0, 12, 0, 1, 0, 0, 0);
      ins("sat_rty", 1, 0, 12, 0, 1, 0, 0, 0);
    end
    chk("sat_cnt", 32'(l_cnt), 15);

    ins("ld_r11", 1, 0, 0, 0, 0, 11, 1, 1);
    ins("use_r11", 1, 11, 0, 1, 0, 0, 0, 0);
    chk("mid_stall", 32'(l_stall), 1);
    ins("use_r11_rst", 1, 11, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_forces0", 32'({l_sel, l_stall}), 0);
    ins("use_r11_post", 1, 11, 0, 1, 0, 0, 0, 0);
    chk("post_rst_sel", 32'(l_sel), 0);
    chk("post_rst_stall", 32'(l_stall), 0);
    chk("post_rst_cnt", 32'(l_cnt), 0);

    for (int i = 0; i < 300; i++) begin
      ins("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Control stage directly upstream of the operand forwarding mux. It generates the four select lines (One_A, One_B, Two_A, Two_B) that choose between the two in-flight result buses, One and Two.
- Tracks the destination registers of the two instructions ahead of decode, in a two-entry shift pipeline.
- Detects load-use hazards, issues a one-cycle stall and inserts a bubble.
- Keeps a saturating stall counter for performance debug.

Parameters:
- REG_BITS, 4, width of register specifiers (16 architectural registers).
- ZERO_REG, 1, when 1, register 0 is hardwired zero and is never forwarded or hazarded.
- CNT_BITS, 16, width of the stall performance counter.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- dec_valid  in  1  decode slot holds a real instruction.
- dec_src_a  in  REG_BITS  operand A source register.
- dec_src_b  in  REG_BITS  operand B source register.
- dec_use_a  in  1  instruction reads src_a.
- dec_use_b  in  1  instruction reads src_b.
- dec_dst  in  REG_BITS  destination register.
- dec_wr  in  1  instruction writes dec_dst.
- dec_load  in  1  instruction is a load (result available only on Two).
- freeze  in  1  global pipeline hold from downstream.
- flush  in  1  kill the decode-slot instruction.
- one_a, one_b  out  1  select One bus for DataA / DataB.
- two_a, two_b  out  1  select Two bus for DataA / DataB.
- stall  out  1  hold decode and fetch this cycle.
- stall_cnt  out  CNT_BITS  number of load-use stall cycles since reset.

Behaviour:
- State:
  - S1 = instruction one ahead of decode; its result drives One. Fields: v1, dst1, wr1, ld1.
  - S2 = instruction two ahead; its result drives Two. Fields: v2, dst2, wr2.
- Match definitions (X is A or B):
  - hit1_X = dec_valid & dec_use_X & v1 & wr1 & (dst1 == dec_src_X) & !(ZERO_REG & dec_src_X == 0).
  - hit2_X: same form against S2.
- Select outputs are combinational, from current inputs and state:
  - one_X = hit1_X & !ld1.
  - two_X = hit2_X & !hit1_X. The youngest producer wins, so one_X and two_X are never both 1.
  - All selects 0 means the downstream mux outputs zero; the register-file path supplies the operand.
- Load-use hazard:
  - stall = (hit1_A | hit1_B) & ld1 & !flush.
  - While stall is 1, one_X is 0 and two_X is 0 for the stalled operand. The next cycle resolves it via Two.
- Shift, on each clk edge when rst = 0:
  - freeze = 1: S1, S2 and stall_cnt hold. Outputs are still evaluated combinationally.
  - Otherwise: S2 <= S1.
  - S1 <= decode fields if dec_valid & !stall & !flush; else bubble (v1 = 0).
  - Upstream must hold the decode instruction while stall = 1.
- stall_cnt:
  - Increments by 1 on each edge where stall & !freeze.
  - Saturates at all-ones and does not wrap.
- Simultaneous events:
  - flush overrides stall: stall forced 0, bubble inserted.
  - freeze overrides everything for state update.
  - Two loads back-to-back to the same register: only S1 is checked for the hazard, giving a single stall.
  - A write to register 0 with ZERO_REG = 1 never matches.
- Reset (synchronous):
  - v1 = v2 = 0, all stored fields 0, stall_cnt = 0.
  - While rst = 1, all outputs are forced 0.
  - Reset mid-stall drops the bubble and hazard immediately. The first cycle after reset sees an empty pipeline.
- Latency: selects and stall are zero-cycle (combinational). State advances by one stage per unfrozen cycle.

Test Plan:
- Reset, then a decode instruction reading r3/r4 with nothing in flight -> all selects 0, stall 0, stall_cnt 0.
- ALU writes r5; next cycle an instruction reads src_a = r5 -> one_a = 1, others 0. One cycle later (bubble in between) an instruction reading src_b = r5 -> two_b = 1.
- Load writes r2; next instruction reads r2 on A -> stall = 1 for exactly one cycle, bubble into S1. Following cycle, same instruction -> two_a = 1, stall = 0. stall_cnt = 1.
- Both S1 and S2 write r7; instruction reads r7 on A and B -> one_a = one_b = 1, two_a = two_b = 0. Repeat with r0 and ZERO_REG = 1 -> all 0.
- Load-use hazard with flush = 1 in the same cycle -> stall 0, S1 bubble. With freeze = 1 -> S1/S2 and stall_cnt unchanged over 3 cycles.
- Force 2^CNT_BITS + 5 stall cycles (CNT_BITS = 4 build) -> stall_cnt saturates at 15. Assert rst mid-stall -> next cycle stall 0, stall_cnt 0, v1 = v2 = 0.
